// File: rtl/mdio_slave_if.sv
// MDIO Clause-22 responder: oversamples MDC/MDIO in the core clock domain and
// turns read/write frames into single-cycle register-bus strobes.
`timescale 1ns/1ps
module mdio_slave_if #(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         PRE_LEN     = 32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  // state   | meaning
  // S_IDLE  | counting preamble ones, waiting for the ST 0
  // S_ST2   | second ST bit (must be 1)
  // S_OP    | two opcode bits
  // S_PHYAD | five PHY address bits
  // S_REGAD | five register address bits
  // S_TA_RD | read turnaround, pad released then driven low
  // S_RDATA | shifting out 16 read bits, then release
  // S_TA_WR | write turnaround, expects 1 then 0
  // S_WDATA | shifting in 16 write bits
  typedef enum logic [3:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA_RD, S_RDATA, S_TA_WR, S_WDATA
  } state_t;

  localparam int PCW = $clog2(PRE_LEN + 1);
  localparam logic [PCW-1:0] PRE_MAX = PCW'(PRE_LEN);

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_d;
  logic                   rise;
  logic                   bit_in;

  state_t         state;
  logic [PCW-1:0] pre_cnt;
  logic [4:0]     bit_cnt;
  logic [15:0]    sr;
  logic           is_read;

  assign rise   = mdc_sync[SYNC_STAGES-1] & ~mdc_d;
  assign bit_in = mdio_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_d     <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_in};
      mdc_d     <= mdc_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      is_read   <= 1'b0;
      mdio_out  <= 1'b0;
      mdio_oen  <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      if (rise) begin
        case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + PCW'(1);
            end else if (pre_cnt == PRE_MAX) begin
              state   <= S_ST2;
              busy    <= 1'b1;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          S_ST2: begin
            bit_cnt <= '0;
            if (bit_in) state <= S_OP;
            else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_OP: begin
            sr      <= {sr[14:0], bit_in};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              case ({sr[0], bit_in})
                2'b10:   begin is_read <= 1'b1; state <= S_PHYAD; end
                2'b01:   begin is_read <= 1'b0; state <= S_PHYAD; end
                default: begin state <= S_IDLE; busy <= 1'b0; end
              endcase
            end
          end
          S_PHYAD: begin
            sr      <= {sr[14:0], bit_in};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              if ({sr[3:0], bit_in} == PHY_ADDR) state <= S_REGAD;
              else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          S_REGAD: begin
            sr      <= {sr[14:0], bit_in};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd4) begin
              bit_cnt  <= '0;
              reg_addr <= {sr[3:0], bit_in};
              if (is_read) begin
                reg_rd <= 1'b1;
                state  <= S_TA_RD;
              end else begin
                state  <= S_TA_WR;
              end
            end
          end
          S_TA_RD: begin
            if (bit_cnt == 5'd0) begin
              mdio_oen <= 1'b1;
              bit_cnt  <= 5'd1;
            end else begin
              // reg_rdata has had a full MDC period to settle since reg_rd
              sr       <= reg_rdata;
              mdio_oen <= 1'b0;
              mdio_out <= 1'b0;
              bit_cnt  <= '0;
              state    <= S_RDATA;
            end
          end
          S_RDATA: begin
            if (bit_cnt == 5'd16) begin
              mdio_oen <= 1'b1;
              mdio_out <= 1'b0;
              bit_cnt  <= '0;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              mdio_out <= sr[15];
              sr       <= {sr[14:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
          S_TA_WR: begin
            if (bit_cnt == 5'd0 && bit_in) begin
              bit_cnt <= 5'd1;
            end else if (bit_cnt == 5'd1 && !bit_in) begin
              bit_cnt <= '0;
              state   <= S_WDATA;
            end else begin
              bit_cnt <= '0;
              state   <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          S_WDATA: begin
            sr      <= {sr[14:0], bit_in};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              reg_wdata <= {sr[14:0], bit_in};
              reg_wr    <= 1'b1;
              bit_cnt   <= '0;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mdio_slave_if.md
Name: mdio_slave_if

Overview:
- MDIO Clause-22 responder for the capture chip. It receives MDC and MDIO from the pad ring, drives MDIO back through the pad's data input and active-low output enable, and converts frames into a simple register-bus read/write strobe interface.
- MDC is oversampled in the core clock domain. No logic runs on MDC directly.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block responds to.
- PRE_LEN, 32, consecutive MDIO ones required as preamble before ST.
- SYNC_STAGES, 2, synchronizer depth for mdc and mdio_in (minimum 2).

Ports:
- clk  input  1  core clock; frequency must be ≥ 8× MDC.
- rst_n  input  1  asynchronous active-low reset.
- mdc  input  1  MDC from pad (asynchronous to clk).
- mdio_in  input  1  MDIO level from pad (asynchronous to clk).
- mdio_out  output  1  data driven to MDIO pad when enabled.
- mdio_oen  output  1  pad output enable, active low (0 = drive, 1 = release).
- reg_addr  output  5  register address of the current or last frame.
- reg_wdata  output  16  write data, valid with reg_wr.
- reg_wr  output  1  one-clk write strobe.
- reg_rd  output  1  one-clk read strobe.
- reg_rdata  input  16  read data; must be valid ≤ 2 clk after reg_rd and held until the frame ends.
- busy  output  1  high from ST detection until return to IDLE.

Behaviour:
- Reset values: mdio_out=0, mdio_oen=1, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, state=IDLE, counters=0.
- mdc and mdio_in each pass through SYNC_STAGES flops, plus one delay flop on mdc.
- Rise event = synced mdc high and delayed mdc low. At each rise event the synced mdio_in is the sampled bit. Pin-to-event latency is SYNC_STAGES+1 clk.
- All state changes and all mdio_out/mdio_oen updates happen only on the clk of a rise event, except the reg_rd/reg_wr strobes and the reset behaviour.
- States and transitions (bits taken one per rise event, MSB first):
  - IDLE: count consecutive ones, saturating at PRE_LEN; a 0 clears the count. When count==PRE_LEN and the bit is 0 → ST2 and busy=1.
  - ST2: bit 1 → OP; bit 0 → IDLE.
  - OP (2 bits): 10 = read, 01 = write. 00 or 11 → IDLE after the second bit.
  - PHYAD (5 bits): after the 5th bit, compare with PHY_ADDR. Mismatch → IDLE with no drive and no strobe.
  - REGAD (5 bits): after the 5th bit, reg_addr is updated.
    - Read: reg_rd pulses the next clk; → TA_RD.
    - Write: → TA_WR.
  - TA_RD: at the 1st TA rise, mdio_oen=1 (released). At the 2nd TA rise, latch reg_rdata, then mdio_oen=0 and mdio_out=0; → RDATA.
  - RDATA: at each of the next 16 rises, drive latched bit 15..0. At the following rise, mdio_oen=1 → IDLE.
  - TA_WR: expect 1 then 0; any other value → IDLE with no strobe.
  - WDATA: shift 16 bits. After the 16th, reg_wdata is updated and reg_wr pulses the next clk → IDLE.
- Returning to IDLE always clears busy and the preamble count. A fresh PRE_LEN preamble is required for every frame.
- mdio_oen is 0 only from the 2nd TA rise of a matched read through the rise after D0 (17 MDC periods). It is never 0 in any other state.
- reg_rd and reg_wr are mutually exclusive, single-cycle, and at most one per frame. reg_addr holds its value between frames.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous), so the pad is released within 0 clk. No strobe is emitted.
- MDC stopping mid-frame: the state holds indefinitely. There is no timeout.
- A glitch-free MDC is the master's responsibility. A low period shorter than 2 clk may be missed.

Test Plan:
- Write frame, PHY_ADDR=1: 32 ones, 01, 01, 00001, 00101, 10, 0xA5C3 → one reg_wr pulse with reg_addr=5 and reg_wdata=0xA5C3; mdio_oen stays 1 throughout.
- Read frame to reg 9 with reg_rdata=0x8001 → one reg_rd pulse with reg_addr=9; MDIO observes Z, 0, then 1000000000000001. mdio_oen=0 for exactly 17 MDC periods, then 1.
- Read frame addressed to PHY 2 → no reg_rd, mdio_oen stays 1; an immediately following valid frame with full preamble is served.
- Preamble of 31 ones then a valid frame body → ignored (no strobes). With 32 ones the frame is accepted.
- Opcode 11, and write TA=00 → no strobes, busy drops, return to IDLE.
- rst_n asserted at read data bit 7 → mdio_oen=1 asynchronously, all outputs at reset values; next full read frame completes correctly.
